// File: rtl/hack_alu_pipe.sv
// hack_alu_pipe -- two-stage pipelined Hack ALU with valid/ready handshakes.
//
// Stage 1 applies the zx/nx and zy/ny pre-processing and registers the
// conditioned operands with f/no. Stage 2 computes add/and, applies the
// optional output inversion and registers the result with its zr/ng flags.
//
// Optional feature macro: HACK_ALU_CARRY_EN
//   When defined, a registered 'carry' output is added: bit 16 of xp+yp when
//   f=1, otherwise 0, independent of 'no'. When undefined the port is absent.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand/control beat valid
//   in_ready   out  a beat can be accepted this cycle (combinational)
//   x, y       in   16-bit operands
//   ctrl       in   {zx,nx,zy,ny,f,no}, zx is the MSB
//   out_valid  out  result beat valid
//   out_ready  in   consumer accepts the result
//   out        out  ALU result
//   zr         out  out == 0
//   ng         out  out[15]
//   carry      out  adder carry (HACK_ALU_CARRY_EN only)

// 16-bit NOT primitive (Hack Not16).
module not16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  assign out = ~in;
endmodule

module hack_alu_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
`ifdef HACK_ALU_CARRY_EN
  ,
  output logic             carry
`endif
);

  // Control field decode
  logic zx, nx, zy, ny, fsel, nosel;
  assign zx    = ctrl[5];
  assign nx    = ctrl[4];
  assign zy    = ctrl[3];
  assign ny    = ctrl[2];
  assign fsel  = ctrl[1];
  assign nosel = ctrl[0];

  // Pipeline state
  logic             s1_valid;
  logic [WIDTH-1:0] s1_xp;
  logic [WIDTH-1:0] s1_yp;
  logic             s1_f;
  logic             s1_no;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_out;
  logic             s2_zr;
  logic             s2_ng;
`ifdef HACK_ALU_CARRY_EN
  logic             s2_carry;
`endif

  // Handshake
  logic s2_free;
  logic s1_adv;
  logic accept;

  assign s2_free  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;

  // Stage 1 pre-processing
  logic [WIDTH-1:0] xz, xz_n, xp;
  logic [WIDTH-1:0] yz, yz_n, yp;

  always_comb begin
    xz = zx ? '0 : x;
    yz = zy ? '0 : y;
  end

  not16 #(.WIDTH(WIDTH)) u_not_nx (.in(xz), .out(xz_n));
  not16 #(.WIDTH(WIDTH)) u_not_ny (.in(yz), .out(yz_n));

  always_comb begin
    xp = nx ? xz_n : xz;
    yp = ny ? yz_n : yz;
  end

  // Stage 2 compute; the 17-bit sum keeps the adder carry visible
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r, r_n, res;
  logic             res_zr;
  logic             res_ng;
  logic             res_carry;

  always_comb begin
    sum       = {1'b0, s1_xp} + {1'b0, s1_yp};
    r         = s1_f ? sum[WIDTH-1:0] : (s1_xp & s1_yp);
    res_carry = s1_f ? sum[WIDTH] : 1'b0;
  end

  not16 #(.WIDTH(WIDTH)) u_not_no (.in(r), .out(r_n));

  always_comb begin
    res    = s1_no ? r_n : r;
    res_zr = (res == '0);
    res_ng = res[WIDTH-1];
  end

`ifndef HACK_ALU_CARRY_EN
  logic unused_carry;
  assign unused_carry = res_carry;
`endif

  // Stage 1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_xp    <= '0;
      s1_yp    <= '0;
      s1_f     <= 1'b0;
      s1_no    <= 1'b0;
    end else begin
      // Refill on accept; otherwise empty when the held beat moves on.
      if (accept) begin
        s1_valid <= 1'b1;
        s1_xp    <= xp;
        s1_yp    <= yp;
        s1_f     <= fsel;
        s1_no    <= nosel;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2 register; data only loads on advance so it holds under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_out   <= '0;
      s2_zr    <= 1'b0;
      s2_ng    <= 1'b0;
`ifdef HACK_ALU_CARRY_EN
      s2_carry <= 1'b0;
`endif
    end else begin
      if (s1_adv) begin
        s2_valid <= 1'b1;
        s2_out   <= res;
        s2_zr    <= res_zr;
        s2_ng    <= res_ng;
`ifdef HACK_ALU_CARRY_EN
        s2_carry <= res_carry;
`endif
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out       = s2_out;
  assign zr        = s2_zr;
  assign ng        = s2_ng;
`ifdef HACK_ALU_CARRY_EN
  assign carry     = s2_carry;
`endif

endmodule

// File: tb/tb_hack_alu_pipe.sv
// tb_hack_alu_pipe -- self-checking bench for hack_alu_pipe.
// Expected results come from a behavioural Hack ALU model and are queued on
// accept, then popped and compared whenever the DUT hands a result over.
module tb_hack_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x, y;
  logic [5:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr, ng;
`ifdef HACK_ALU_CARRY_EN
  logic        carry;
`endif

  always #5 clk = ~clk;

  hack_alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng)
`ifdef HACK_ALU_CARRY_EN
    , .carry(carry)
`endif
  );

  int ncomp = 0;
  int nfail = 0;
  logic [18:0] sb[$];   // {carry, zr, ng, out}
  logic last_acc;

  function automatic logic [18:0] model(input logic [15:0] a0, input logic [15:0] b0,
                                        input logic [5:0] c);
    logic [15:0] a, b, o;
    logic [16:0] s;
    logic        cy;
    a = a0; b = b0;
    if (c[5]) a = 16'h0000;
    if (c[4]) a = a ^ 16'hFFFF;
    if (c[3]) b = 16'h0000;
    if (c[2]) b = b ^ 16'hFFFF;
    s  = 17'(a) + 17'(b);
    o  = c[1] ? s[15:0] : (a & b);
    cy = c[1] ? s[16] : 1'b0;
    if (c[0]) o = o ^ 16'hFFFF;
    return {cy, (o == 16'h0000), o[15], o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, score, then advance past the edge.
  task automatic tick();
    logic [18:0] e;
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      ncomp++;
      assert (sb.size() > 0) else begin
        nfail++;
        $error("FAIL sb_unexpected: observed result %h expected none", out);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_out", 32'(out), 32'(e[15:0]));
        chk("sb_ng", 32'(ng), 32'(e[16]));
        chk("sb_zr", 32'(zr), 32'(e[17]));
        chk("sb_zr_consistent", 32'(zr), 32'(out == 16'h0000));
`ifdef HACK_ALU_CARRY_EN
        chk("sb_carry", 32'(carry), 32'(e[18]));
`endif
      end
    end
    if (last_acc) sb.push_back(model(x, y, ctrl));
    @(posedge clk);
    #1;
  endtask

  // Single beat through an empty pipe with constant expectations.
  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [5:0] c, input logic [15:0] eo,
                         input logic ez, input logic en);
    x = a; y = b; ctrl = c; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk({tag, "_acc"}, 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    chk({tag, "_lat_s1"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_out"}, 32'(out), 32'(eo));
    chk({tag, "_zr"}, 32'(zr), 32'(ez));
    chk({tag, "_ng"}, 32'(ng), 32'(en));
    tick();
    chk({tag, "_one_cycle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int sent;
    int cyc;
    logic [15:0] held;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; ctrl = '0; last_acc = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_zr", 32'(zr), 32'd0);
    chk("rst_ng", 32'(ng), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed operations
    run_one("add",   16'h0005, 16'h0003, 6'b000010, 16'h0008, 1'b0, 1'b0);
    run_one("x_m_y", 16'h0003, 16'h0005, 6'b010011, 16'hFFFE, 1'b0, 1'b1);
    run_one("zero",  16'h1234, 16'h5678, 6'b101010, 16'h0000, 1'b1, 1'b0);
    run_one("minus1",16'h1234, 16'h5678, 6'b111010, 16'hFFFF, 1'b0, 1'b1);
`ifdef HACK_ALU_CARRY_EN
    run_one("c_add", 16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1'b1, 1'b0);
    run_one("c_and", 16'hFFFF, 16'h0001, 6'b000000, 16'h0001, 1'b0, 1'b0);
`endif

    // Backpressure: three beats, output stalled
    out_ready = 1'b0; in_valid = 1'b1;
    x = 16'h0010; y = 16'h0020; ctrl = 6'b000010; tick();
    chk("bp_acc1", 32'(last_acc), 32'd1);
    x = 16'h00F0; y = 16'h0F0F; ctrl = 6'b000000; tick();
    chk("bp_acc2", 32'(last_acc), 32'd1);
    x = 16'h7FFF; y = 16'h0001; ctrl = 6'b000010;
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    held = out;
    chk("bp_head", 32'(held), 32'h0030);
    tick(); tick();
    chk("bp_hold_acc", 32'(last_acc), 32'd0);
    chk("bp_hold_out", 32'(out), 32'h0030);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    cyc = 0;
    do begin tick(); cyc++; end while (!last_acc && cyc < 10);
    chk("bp_third_acc", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    cyc = 0;
    while ((sb.size() > 0 || out_valid) && cyc < 20) begin tick(); cyc++; end
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Random streaming with random stalls on both sides
    sent = 0; cyc = 0; in_valid = 1'b0;
    while (sent < 100 && cyc < 3000) begin
      if (!in_valid && ($urandom_range(3) != 0)) begin
        x = 16'($urandom); y = 16'($urandom); ctrl = 6'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(2) != 0);
      tick();
      cyc++;
      if (last_acc) begin sent++; in_valid = 1'b0; end
    end
    chk("stream_sent", 32'(sent), 32'd100);
    in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
    while ((sb.size() > 0 || out_valid) && cyc < 20) begin tick(); cyc++; end
    chk("stream_drained", 32'(sb.size()), 32'd0);

    // Reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1;
    x = 16'h0001; y = 16'h0001; ctrl = 6'b000010; tick();
    x = 16'h0002; y = 16'h0002; tick();
    in_valid = 1'b0;
    chk("rm_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rm_out_valid", 32'(out_valid), 32'd0);
    chk("rm_out", 32'(out), 32'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rm_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("rm_no_stale", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
